// File: rtl/cell_reveal_engine_if.sv
// Player command / board status bundle for cell_reveal_engine.
// master: command source (player input logic); slave: the reveal engine.
interface cell_reveal_engine_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic          btn_up;
  logic          btn_down;
  logic          btn_left;
  logic          btn_right;
  logic          btn_reveal;
  logic          btn_flag;
  logic [RW-1:0] cursor_row;
  logic [CW-1:0] cursor_col;
  logic [N-1:0]  revealed;
  logic [N-1:0]  flagged;
  logic          busy;
  logic          game_lost;
  logic          game_won;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag,
    input  cursor_row, cursor_col, revealed, flagged, busy, game_lost, game_won
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag,
    output cursor_row, cursor_col, revealed, flagged, busy, game_lost, game_won
  );
endinterface

// File: rtl/cell_reveal_engine.sv
// Minesweeper gameplay stage: cursor, reveal/flag bitmaps and BFS flood fill
// from zero-count cells, with sticky lose/win reporting.
// Optional macro SHOW_BOMBS_ON_LOSS_EN: on a loss, expose every bomb cell and
// clear the flags on them in the same cycle game_lost rises.
module cell_reveal_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int CNT_W = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ROWS*COLS-1:0]               board_bomb,
  input  logic [ROWS*COLS*CNT_W-1:0]         board_count,
  input  logic [$clog2(ROWS*COLS):0]         bomb_total,
  cell_reveal_engine_if.slave                ctrl
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  typedef enum logic [2:0] {IDLE, POP, SCAN, CHECK, LOST, WON} state_t;

  state_t           state, state_n;
  logic [N-1:0]     revealed, revealed_n;
  logic [N-1:0]     flagged, flagged_n;
  logic [RW-1:0]    row, row_n;
  logic [CW-1:0]    col, col_n;
  logic [IDX_W-1:0] cur, cur_n;
  logic [2:0]       k, k_n;

  logic             push, pop;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] q_mem [N];
  logic [IDX_W-1:0] q_head, q_tail;
  logic [IDX_W:0]   q_cnt;
  logic             q_empty, q_full;

  logic [IDX_W-1:0] sel, nb;
  logic             nb_ok, all_safe;
  int               r0, c0, nr, nc, dr, dc;
  int unsigned      pc;

  function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(N - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  assign q_empty = (q_cnt == '0);
  assign q_full  = (q_cnt == (IDX_W+1)'(N));
  assign sel     = IDX_W'(int'(row) * COLS + int'(col));

  // Neighbour k of the popped cell; off-board positions are flagged invalid rather than wrapped.
  always_comb begin
    r0 = int'(cur) / COLS;
    c0 = int'(cur) % COLS;
    dr = 1;
    dc = 1;
    case (k)
      3'd0:    begin dr = -1; dc = -1; end
      3'd1:    begin dr = -1; dc =  0; end
      3'd2:    begin dr = -1; dc =  1; end
      3'd3:    begin dr =  0; dc = -1; end
      3'd4:    begin dr =  0; dc =  1; end
      3'd5:    begin dr =  1; dc = -1; end
      3'd6:    begin dr =  1; dc =  0; end
      default: begin dr =  1; dc =  1; end
    endcase
    nr    = r0 + dr;
    nc    = c0 + dc;
    nb_ok = (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
    nb    = nb_ok ? IDX_W'(nr * COLS + nc) : '0;
  end

  // Win test: every non-bomb cell revealed.
  always_comb begin
    pc = 0;
    for (int unsigned i = 0; i < N; i++) pc += 32'(revealed[i]);
    all_safe = (pc + 32'(bomb_total)) == 32'(N);
  end

  // Next-state, bitmap, cursor and queue-control logic.
  always_comb begin
    state_n    = state;
    revealed_n = revealed;
    flagged_n  = flagged;
    row_n      = row;
    col_n      = col;
    cur_n      = cur;
    k_n        = k;
    push       = 1'b0;
    pop        = 1'b0;
    push_idx   = '0;
    case (state)
      IDLE: begin
        if (ctrl.btn_reveal) begin
          if (!revealed[sel] && !flagged[sel]) begin
            revealed_n[sel] = 1'b1;
            if (board_bomb[sel]) begin
              state_n = LOST;
`ifdef SHOW_BOMBS_ON_LOSS_EN
              revealed_n = revealed_n | board_bomb;
              flagged_n  = flagged & ~board_bomb;
`endif
            end else if (board_count[int'(sel)*CNT_W +: CNT_W] == '0) begin
              push     = 1'b1;
              push_idx = sel;
              state_n  = POP;
            end else begin
              state_n = CHECK;
            end
          end
        end else if (ctrl.btn_flag) begin
          if (!revealed[sel]) flagged_n[sel] = ~flagged[sel];
        end else if (ctrl.btn_up) begin
          row_n = (row == '0) ? RW'(ROWS - 1) : row - RW'(1);
        end else if (ctrl.btn_down) begin
          row_n = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
        end else if (ctrl.btn_left) begin
          col_n = (col == '0) ? CW'(COLS - 1) : col - CW'(1);
        end else if (ctrl.btn_right) begin
          col_n = (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
        end
      end
      POP: begin
        if (q_empty) begin
          state_n = CHECK;
        end else begin
          pop     = 1'b1;
          cur_n   = q_mem[q_head];
          k_n     = '0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        // Marking on push keeps every cell in the queue at most once.
        if (nb_ok && !revealed[nb] && !flagged[nb] && !board_bomb[nb]) begin
          revealed_n[nb] = 1'b1;
          if (board_count[int'(nb)*CNT_W +: CNT_W] == '0) begin
            push     = 1'b1;
            push_idx = nb;
          end
        end
        if (k == 3'd7) state_n = POP;
        else           k_n     = k + 3'd1;
      end
      CHECK:   state_n = all_safe ? WON : IDLE;
      LOST:    state_n = LOST;
      WON:     state_n = WON;
      default: state_n = IDLE;
    endcase
  end

  // FSM and game-state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      revealed <= '0;
      flagged  <= '0;
      row      <= '0;
      col      <= '0;
      cur      <= '0;
      k        <= '0;
    end else begin
      state    <= state_n;
      revealed <= revealed_n;
      flagged  <= flagged_n;
      row      <= row_n;
      col      <= col_n;
      cur      <= cur_n;
      k        <= k_n;
    end
  end

  // BFS queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_head <= '0;
      q_tail <= '0;
      q_cnt  <= '0;
    end else begin
      if (push && !q_full)  q_tail <= ptr_next(q_tail);
      if (pop && !q_empty)  q_head <= ptr_next(q_head);
      case ({push && !q_full, pop && !q_empty})
        2'b10:   q_cnt <= q_cnt + (IDX_W+1)'(1);
        2'b01:   q_cnt <= q_cnt - (IDX_W+1)'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // BFS queue storage.
  always_ff @(posedge clk) begin
    if (push && !q_full) q_mem[q_tail] <= push_idx;
  end

  assign ctrl.cursor_row = row;
  assign ctrl.cursor_col = col;
  assign ctrl.revealed   = revealed;
  assign ctrl.flagged    = flagged;
  assign ctrl.busy       = (state == POP) || (state == SCAN);
  assign ctrl.game_lost  = (state == LOST);
  assign ctrl.game_won   = (state == WON);
endmodule

// File: tb/tb_cell_reveal_engine.sv
// Directed bench for cell_reveal_engine (8x8 board): table-driven command
// vectors plus hand sequences for flood fill, loss, win and mid-fill reset.
module tb_cell_reveal_engine;
  localparam logic [5:0] B_NONE = 6'b000000;
  localparam logic [5:0] B_REV  = 6'b100000;
  localparam logic [5:0] B_FLG  = 6'b010000;
  localparam logic [5:0] B_UP   = 6'b001000;
  localparam logic [5:0] B_DN   = 6'b000100;
  localparam logic [5:0] B_LF   = 6'b000010;
  localparam logic [5:0] B_RT   = 6'b000001;
  localparam logic [63:0] ONE   = 64'd1;
  localparam logic [63:0] ALL_BUT_63 = 64'h7FFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] board_bomb = '0;
  logic [255:0] board_count = '0;
  logic [6:0]  bomb_total = '0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  cell_reveal_engine_if #(.ROWS(8), .COLS(8)) ctrl ();

  cell_reveal_engine #(.ROWS(8), .COLS(8), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .board_bomb  (board_bomb),
    .board_count (board_count),
    .bomb_total  (bomb_total),
    .ctrl        (ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  btn;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [63:0] rev;
    logic [63:0] flg;
    logic        lost;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_board(input logic [63:0] bombs);
    int cnt;
    board_bomb = bombs;
    bomb_total = '0;
    for (int i = 0; i < 64; i++) if (bombs[i]) bomb_total = bomb_total + 7'd1;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < 8 && c+dc >= 0 && c+dc < 8)
              if (bombs[(r+dr)*8 + (c+dc)]) cnt++;
        board_count[(r*8+c)*4 +: 4] = 4'(cnt);
      end
    end
  endtask

  task automatic drive(input logic [5:0] b);
    {ctrl.btn_reveal, ctrl.btn_flag, ctrl.btn_up, ctrl.btn_down, ctrl.btn_left, ctrl.btn_right} = b;
  endtask

  // Drive buttons for one clock edge; returns at the next falling edge.
  task automatic press(input logic [5:0] b);
    drive(b);
    @(negedge clk);
    drive(B_NONE);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(B_NONE);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_not_busy(input string name);
    int cyc;
    cyc = 0;
    while (ctrl.busy === 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_timeout"}, 64'(cyc < 3000), 64'd1);
  endtask

  initial begin
    drive(B_NONE);
    vecs[0]  = '{B_NONE,                    3'd0, 3'd0, '0,          '0,         1'b0};
    vecs[1]  = '{B_UP,                      3'd7, 3'd0, '0,          '0,         1'b0};
    vecs[2]  = '{B_LF,                      3'd7, 3'd7, '0,          '0,         1'b0};
    vecs[3]  = '{B_DN,                      3'd0, 3'd7, '0,          '0,         1'b0};
    vecs[4]  = '{B_RT,                      3'd0, 3'd0, '0,          '0,         1'b0};
    vecs[5]  = '{B_DN,                      3'd1, 3'd0, '0,          '0,         1'b0};
    vecs[6]  = '{B_RT,                      3'd1, 3'd1, '0,          '0,         1'b0};
    vecs[7]  = '{B_FLG,                     3'd1, 3'd1, '0,          ONE << 9,   1'b0};
    vecs[8]  = '{B_REV,                     3'd1, 3'd1, '0,          ONE << 9,   1'b0};
    vecs[9]  = '{B_FLG,                     3'd1, 3'd1, '0,          '0,         1'b0};
    vecs[10] = '{B_DN,                      3'd2, 3'd1, '0,          '0,         1'b0};
    vecs[11] = '{B_RT,                      3'd2, 3'd2, '0,          '0,         1'b0};
    vecs[12] = '{B_REV | B_FLG | B_UP | B_LF, 3'd2, 3'd2, ONE << 18, '0,         1'b0};
    vecs[13] = '{B_NONE,                    3'd2, 3'd2, ONE << 18,   '0,         1'b0};
    vecs[14] = '{B_FLG,                     3'd2, 3'd2, ONE << 18,   '0,         1'b0};
    vecs[15] = '{B_UP,                      3'd1, 3'd2, ONE << 18,   '0,         1'b0};

    // Table: bombs at 9 and 27, cell 18 has count 2.
    set_board((ONE << 9) | (ONE << 27));
    do_reset();
    @(negedge clk);
    chk("reset_busy", 64'(ctrl.busy), 64'd0);
    chk("reset_won", 64'(ctrl.game_won), 64'd0);
    for (int i = 0; i < 16; i++) begin
      press(vecs[i].btn);
      chk($sformatf("vec%0d_row", i), 64'(ctrl.cursor_row), 64'(vecs[i].row));
      chk($sformatf("vec%0d_col", i), 64'(ctrl.cursor_col), 64'(vecs[i].col));
      chk($sformatf("vec%0d_rev", i), ctrl.revealed, vecs[i].rev);
      chk($sformatf("vec%0d_flg", i), ctrl.flagged, vecs[i].flg);
      chk($sformatf("vec%0d_lost", i), 64'(ctrl.game_lost), 64'(vecs[i].lost));
      chk($sformatf("vec%0d_busy", i), 64'(ctrl.busy), 64'd0);
    end
    chk("table_won", 64'(ctrl.game_won), 64'd0);

    // Loss on bomb 27 with a flag on bomb 9.
    do_reset();
    press(B_DN); press(B_RT); press(B_FLG);
    press(B_DN); press(B_DN); press(B_RT); press(B_RT);
    chk("lose_pre_flg", ctrl.flagged, ONE << 9);
    press(B_REV);
    chk("lose_lost", 64'(ctrl.game_lost), 64'd1);
`ifdef SHOW_BOMBS_ON_LOSS_EN
    chk("lose_rev", ctrl.revealed, (ONE << 9) | (ONE << 27));
    chk("lose_flg", ctrl.flagged, '0);
`else
    chk("lose_rev", ctrl.revealed, ONE << 27);
    chk("lose_flg", ctrl.flagged, ONE << 9);
`endif
    press(B_UP); press(B_FLG); press(B_LF); press(B_REV);
    chk("lost_row", 64'(ctrl.cursor_row), 64'd3);
    chk("lost_col", 64'(ctrl.cursor_col), 64'd3);
`ifdef SHOW_BOMBS_ON_LOSS_EN
    chk("lost_rev_frozen", ctrl.revealed, (ONE << 9) | (ONE << 27));
    chk("lost_flg_frozen", ctrl.flagged, '0);
`else
    chk("lost_rev_frozen", ctrl.revealed, ONE << 27);
    chk("lost_flg_frozen", ctrl.flagged, ONE << 9);
`endif
    chk("lost_sticky", 64'(ctrl.game_lost), 64'd1);
    chk("lost_won", 64'(ctrl.game_won), 64'd0);

    // Flood fill to a win: single bomb at 63.
    set_board(ONE << 63);
    do_reset();
    press(B_REV);
    chk("fill_busy", 64'(ctrl.busy), 64'd1);
    press(B_DN);
    chk("fill_busy_hold", 64'(ctrl.busy), 64'd1);
    wait_not_busy("fill");
    chk("fill_rev", ctrl.revealed, ALL_BUT_63);
    chk("fill_won_early", 64'(ctrl.game_won), 64'd0);
    @(negedge clk);
    chk("fill_won", 64'(ctrl.game_won), 64'd1);
    chk("fill_row", 64'(ctrl.cursor_row), 64'd0);
    press(B_RT);
    chk("won_col", 64'(ctrl.cursor_col), 64'd0);
    chk("won_sticky", 64'(ctrl.game_won), 64'd1);

    // Reset 20 cycles into the fill, then restart.
    do_reset();
    press(B_REV);
    repeat (20) @(negedge clk);
    chk("midfill_busy", 64'(ctrl.busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rev", ctrl.revealed, '0);
    chk("rst_flg", ctrl.flagged, '0);
    chk("rst_busy", 64'(ctrl.busy), 64'd0);
    chk("rst_lost", 64'(ctrl.game_lost), 64'd0);
    chk("rst_won", 64'(ctrl.game_won), 64'd0);
    chk("rst_cursor", {58'd0, ctrl.cursor_row, ctrl.cursor_col}, '0);
    reset = 1'b1;
    @(negedge clk);
    press(B_REV);
    chk("restart_busy", 64'(ctrl.busy), 64'd1);
    wait_not_busy("restart");
    @(negedge clk);
    chk("restart_rev", ctrl.revealed, ALL_BUT_63);
    chk("restart_won", 64'(ctrl.game_won), 64'd1);

    // No bombs: one reveal uncovers the whole board and wins.
    set_board('0);
    do_reset();
    press(B_REV);
    wait_not_busy("nobomb");
    @(negedge clk);
    chk("nobomb_rev", ctrl.revealed, '1);
    chk("nobomb_won", 64'(ctrl.game_won), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
